// File: rtl/tx_framer.sv
// Packet framer feeding an 8b10b encoder: wraps upstream bytes as
// K27.7 SOP, payload, XOR checksum, K29.7 EOP, with K28.5 idles and fillers.
module tx_framer #(
    parameter int IDLE_GAP = 2,
    parameter int MAX_LEN  = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       k_out,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       len_err
);

    localparam int             CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]  MAX_C    = CW'(MAX_LEN);
    localparam logic [CW-1:0]  ONE_C    = CW'(1);
    localparam logic [3:0]     GAP_C    = 4'(IDLE_GAP);
    localparam logic [7:0]     SYM_IDLE = 8'hBC;
    localparam logic [7:0]     SYM_SOP  = 8'hFB;
    localparam logic [7:0]     SYM_EOP  = 8'hFD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOP  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_EOP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            k_q, k_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      chk_q, chk_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gap_q, gap_d;
    logic [3:0]      gap_inc;
    logic            trunc_q, trunc_d;

    // Next-state and next-symbol selection.
    always_comb begin
        state_d = state_q;
        k_d     = 1'b1;
        data_d  = SYM_IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
        chk_d   = chk_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        trunc_d = trunc_q;
        // gap_inc counts idle symbols including the one emitted this cycle,
        // so IDLE_GAP idles separate EOP from SOP (never fewer than one).
        if (gap_q >= GAP_C) begin
            gap_inc = gap_q;
        end else begin
            gap_inc = gap_q + 4'd1;
        end
        case (state_q)
            ST_IDLE: begin
                gap_d = gap_inc;
                if (s_valid && (gap_inc >= GAP_C)) begin
                    state_d = ST_SOP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SOP: begin
                data_d  = SYM_SOP;
                chk_d   = 8'h00;
                cnt_d   = '0;
                trunc_d = 1'b0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (s_valid) begin
                    k_d    = 1'b0;
                    data_d = s_data;
                    chk_d  = chk_q ^ s_data;
                    cnt_d  = cnt_q + ONE_C;
                    if (s_last || ((cnt_q + ONE_C) == MAX_C)) begin
                        trunc_d = ~s_last;
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
                k_d     = 1'b0;
                data_d  = chk_q;
                err_d   = trunc_q;
                state_d = ST_EOP;
            end
            ST_EOP: begin
                data_d  = SYM_EOP;
                done_d  = 1'b1;
                gap_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered symbol outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= 1'b1;
            data_q  <= SYM_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            chk_q   <= 8'h00;
            cnt_q   <= '0;
            gap_q   <= GAP_C;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            trunc_q <= trunc_d;
        end
    end

    assign s_ready  = (state_q == ST_DATA);
    assign k_out    = k_q;
    assign data_out = data_q;
    assign pkt_done = done_q;
    assign len_err  = err_q;

endmodule
